// File: rtl/rv_pkg.sv
// rv_pkg -- shared RV32I decode definitions for the ID/register-read slice.
//   XLEN_DEF     : default datapath width
//   OPC_*        : major opcodes handled by the decoder
//   F3_* / F7_*  : funct3 / funct7 field constants
//   alu_op_e     : out_op encoding handed to the execute stage
//   dec_t        : result of the field-level decode
//   idx_ok()     : register index range check against NREG
//   decode()     : opcode/funct decode, register range checks excluded
package rv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SLT  = 4'd3,
        OP_SLTU = 4'd4,
        OP_XOR  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_OR   = 4'd8,
        OP_AND  = 4'd9
    } alu_op_e;

    typedef struct packed {
        alu_op_e op;
        logic    illegal;
        logic    use_imm;
        logic    use_rs2;
        logic    shamt;
    } dec_t;

    function automatic logic idx_ok(input logic [4:0] idx, input int nreg);
        return {27'b0, idx} < 32'(nreg);
    endfunction

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t       d;
        logic [6:0] opc;
        logic [6:0] f7;
        logic [2:0] f3;
        opc = instr[6:0];
        f3  = instr[14:12];
        f7  = instr[31:25];
        d   = '{op: OP_ADD, illegal: 1'b0, use_imm: 1'b0, use_rs2: 1'b0, shamt: 1'b0};
        if (opc == OPC_OP) begin
            d.use_rs2 = 1'b1;
            case (f3)
                F3_ADD: begin
                    if (f7 == F7_BASE)     d.op = OP_ADD;
                    else if (f7 == F7_ALT) d.op = OP_SUB;
                    else                   d.illegal = 1'b1;
                end
                F3_SR: begin
                    if (f7 == F7_BASE)     d.op = OP_SRL;
                    else if (f7 == F7_ALT) d.op = OP_SRA;
                    else                   d.illegal = 1'b1;
                end
                default: begin
                    // Remaining R-type ops have no alternate funct7 form.
                    d.illegal = (f7 != F7_BASE);
                    case (f3)
                        F3_SLL:  d.op = OP_SLL;
                        F3_SLT:  d.op = OP_SLT;
                        F3_SLTU: d.op = OP_SLTU;
                        F3_XOR:  d.op = OP_XOR;
                        F3_OR:   d.op = OP_OR;
                        default: d.op = OP_AND;
                    endcase
                end
            endcase
        end else if (opc == OPC_OP_IMM) begin
            d.use_imm = 1'b1;
            case (f3)
                F3_ADD:  d.op = OP_ADD;
                F3_SLT:  d.op = OP_SLT;
                F3_SLTU: d.op = OP_SLTU;
                F3_XOR:  d.op = OP_XOR;
                F3_OR:   d.op = OP_OR;
                F3_AND:  d.op = OP_AND;
                F3_SLL: begin
                    d.shamt   = 1'b1;
                    d.op      = OP_SLL;
                    d.illegal = (f7 != F7_BASE);
                end
                default: begin
                    d.shamt = 1'b1;
                    if (f7 == F7_BASE)     d.op = OP_SRL;
                    else if (f7 == F7_ALT) d.op = OP_SRA;
                    else                   d.illegal = 1'b1;
                end
            endcase
        end else begin
            d.illegal = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/id_regread_if.sv
// id_regread_if -- bundle of the instruction handshake, decoded-operand
// handshake and writeback bus of id_regread.
//   in_valid/in_ready/in_instr        : instruction in
//   out_valid/out_ready/out_*         : decoded operands out
//   wb_en/wb_rd/wb_data               : register writeback from a later stage
// Modports: slave = id_regread side, master = producer/consumer side.
interface id_regread_if #(
    parameter int XLEN = rv_pkg::XLEN_DEF
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_op;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;
    logic [XLEN-1:0] out_imm;
    logic            out_use_imm;
    logic            out_illegal;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    modport slave (
        input  in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
        output in_ready, out_valid, out_op, out_rd, out_rs1_data, out_rs2_data,
               out_imm, out_use_imm, out_illegal
    );

    modport master (
        output in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
        input  in_ready, out_valid, out_op, out_rd, out_rs1_data, out_rs2_data,
               out_imm, out_use_imm, out_illegal
    );
endinterface

// File: rtl/regfile_np.sv
// regfile_np -- NREG x XLEN register file, two combinational read ports,
// one write port with write-first bypass. x0 is hard-wired to zero and
// indices >= NREG read as zero and are never written.
//   clk, rst (sync, active-low) ; we/waddr/wdata ; raddr1/rdata1 ; raddr2/rdata2
module regfile_np
    import rv_pkg::*;
#(
    parameter int NREG = 32,
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] mem [NREG];
    logic            wr_ok;

    assign wr_ok = we && (waddr != 5'd0) && idx_ok(waddr, NREG);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[waddr[AW-1:0]] <= wdata;
        end
    end

    // Same-cycle writeback is forwarded so a reader never sees the stale entry.
    assign rdata1 = ((raddr1 == 5'd0) || !idx_ok(raddr1, NREG)) ? '0 :
                    (wr_ok && (waddr == raddr1)) ? wdata : mem[raddr1[AW-1:0]];
    assign rdata2 = ((raddr2 == 5'd0) || !idx_ok(raddr2, NREG)) ? '0 :
                    (wr_ok && (waddr == raddr2)) ? wdata : mem[raddr2[AW-1:0]];

endmodule

// File: rtl/id_regread.sv
// id_regread -- RV32I decode + register read stage with a pending-write
// scoreboard and a one-deep registered output.
//   clk : clock, all state on rising edge
//   rst : synchronous active-low reset
//   bus : id_regread_if.slave (instruction in, operands out, writeback in)
// Parameters: XLEN datapath width, NREG register count (16 or 32),
// SB_EN enables hazard stalls from the busy scoreboard.
module id_regread
    import rv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREG  = 32,
    parameter int SB_EN = 1
) (
    input  logic         clk,
    input  logic         rst,
    id_regread_if.slave  bus
);
    localparam int AW = $clog2(NREG);

    logic [4:0]      rs1_p0, rs2_p0, rd_p0;
    dec_t            dec_p0;
    logic            illegal_p0, hazard_p0, ready_p0, accept_p0;
    logic [XLEN-1:0] rdata1_p0, rdata2_p0, imm_p0;
    logic [NREG-1:0] busy_q, set_mask, clr_mask;

    logic            vld_p1, use_imm_p1, illegal_p1;
    alu_op_e         op_p1;
    logic [4:0]      rd_p1;
    logic [XLEN-1:0] rs1_p1, rs2_p1, imm_p1;

    // Pending write on idx that is not being retired by this cycle's writeback.
    function automatic logic pending(input logic [NREG-1:0] busy, input logic [4:0] idx,
                                     input logic wen, input logic [4:0] wrd);
        if (!idx_ok(idx, NREG)) return 1'b0;
        return busy[idx[AW-1:0]] && !(wen && (wrd == idx));
    endfunction

    // ---- stage p0: decode, register read, hazard ----
    assign rs1_p0 = bus.in_instr[19:15];
    assign rs2_p0 = bus.in_instr[24:20];
    assign rd_p0  = bus.in_instr[11:7];
    assign dec_p0 = decode(bus.in_instr);

    // rs2 is only a register index for R-type; in I-type it is immediate bits.
    assign illegal_p0 = dec_p0.illegal || !idx_ok(rs1_p0, NREG) || !idx_ok(rd_p0, NREG) ||
                        (dec_p0.use_rs2 && !idx_ok(rs2_p0, NREG));

    regfile_np #(.NREG(NREG), .XLEN(XLEN)) u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (bus.wb_en),
        .waddr  (bus.wb_rd),
        .wdata  (bus.wb_data),
        .raddr1 (rs1_p0),
        .raddr2 (rs2_p0),
        .rdata1 (rdata1_p0),
        .rdata2 (rdata2_p0)
    );

    always_comb begin
        imm_p0 = '0;
        if (dec_p0.use_imm) begin
            if (dec_p0.shamt) imm_p0 = {{(XLEN-5){1'b0}}, bus.in_instr[24:20]};
            else              imm_p0 = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
        end
    end

    // Illegal instructions never reach the scoreboard, so they do not stall.
    assign hazard_p0 = (SB_EN != 0) && !illegal_p0 &&
                       (pending(busy_q, rs1_p0, bus.wb_en, bus.wb_rd) ||
                        (dec_p0.use_rs2 && pending(busy_q, rs2_p0, bus.wb_en, bus.wb_rd)) ||
                        pending(busy_q, rd_p0, bus.wb_en, bus.wb_rd));

    assign ready_p0     = (!vld_p1 || bus.out_ready) && !hazard_p0;
    assign accept_p0    = bus.in_valid && ready_p0;
    assign bus.in_ready = ready_p0;

    // Set is applied after clear so a same-cycle set/clear leaves the bit set.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (bus.wb_en && (bus.wb_rd != 5'd0) && idx_ok(bus.wb_rd, NREG))
            clr_mask[bus.wb_rd[AW-1:0]] = 1'b1;
        if (accept_p0 && !illegal_p0 && (rd_p0 != 5'd0))
            set_mask[rd_p0[AW-1:0]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= (busy_q & ~clr_mask) | set_mask;
    end

    // ---- stage p1: output register ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p1     <= 1'b0;
            op_p1      <= OP_ADD;
            rd_p1      <= '0;
            rs1_p1     <= '0;
            rs2_p1     <= '0;
            imm_p1     <= '0;
            use_imm_p1 <= 1'b0;
            illegal_p1 <= 1'b0;
        end else if (accept_p0) begin
            vld_p1     <= 1'b1;
            op_p1      <= illegal_p0 ? OP_ADD : dec_p0.op;
            rd_p1      <= illegal_p0 ? 5'd0 : rd_p0;
            rs1_p1     <= rdata1_p0;
            rs2_p1     <= dec_p0.use_rs2 ? rdata2_p0 : '0;
            imm_p1     <= imm_p0;
            use_imm_p1 <= dec_p0.use_imm;
            illegal_p1 <= illegal_p0;
        end else if (bus.out_ready) begin
            vld_p1     <= 1'b0;
        end
    end

    assign bus.out_valid    = vld_p1;
    assign bus.out_op       = op_p1;
    assign bus.out_rd       = rd_p1;
    assign bus.out_rs1_data = rs1_p1;
    assign bus.out_rs2_data = rs2_p1;
    assign bus.out_imm      = imm_p1;
    assign bus.out_use_imm  = use_imm_p1;
    assign bus.out_illegal  = illegal_p1;

endmodule

// File: tb/tb_id_regread.sv
// tb_id_regread -- directed scoreboard bench for id_regread (NREG=32 and NREG=16 instances).
module tb_id_regread;
    import rv_pkg::*;

    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        use_imm;
        logic        illegal;
    } rec_t;

    typedef struct {
        logic sel;
        rec_t r;
        rec_t m;
    } sb_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    sb_t  q[$];
    rec_t m_full;
    rec_t m_ill;

    id_regread_if #(.XLEN(32)) b32 ();
    id_regread_if #(.XLEN(32)) b16 ();

    id_regread #(.XLEN(32), .NREG(32), .SB_EN(1)) u32 (.clk(clk), .rst(rst), .bus(b32));
    id_regread #(.XLEN(32), .NREG(16), .SB_EN(1)) u16 (.clk(clk), .rst(rst), .bus(b16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    function automatic rec_t mk(input logic [3:0] op, input logic [4:0] rd, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] imm,
                                input logic ui, input logic il);
        return '{op: op, rd: rd, rs1: a, rs2: b, imm: imm, use_imm: ui, illegal: il};
    endfunction

    function automatic rec_t obs32();
        return '{op: b32.out_op, rd: b32.out_rd, rs1: b32.out_rs1_data, rs2: b32.out_rs2_data,
                 imm: b32.out_imm, use_imm: b32.out_use_imm, illegal: b32.out_illegal};
    endfunction

    function automatic rec_t obs16();
        return '{op: b16.out_op, rd: b16.out_rd, rs1: b16.out_rs1_data, rs2: b16.out_rs2_data,
                 imm: b16.out_imm, use_imm: b16.out_use_imm, illegal: b16.out_illegal};
    endfunction

    function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OPC_OP};
    endfunction

    function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, OPC_OP_IMM};
    endfunction

    task automatic pop_chk(input string tag, input logic sel);
        sb_t  e;
        rec_t o;
        logic ov;
        o  = sel ? obs16() : obs32();
        ov = sel ? b16.out_valid : b32.out_valid;
        chk({tag, "_vld"}, 128'(ov), 128'(1'b1));
        if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = q.pop_front();
            chk(tag, 128'(o & e.m), 128'(e.r & e.m));
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        m_full = '1;
        m_ill  = '0;
        m_ill.rd      = '1;
        m_ill.illegal = 1'b1;

        rst = 1'b0;
        b32.in_valid = 1'b0; b32.in_instr = '0; b32.out_ready = 1'b1;
        b32.wb_en = 1'b0; b32.wb_rd = '0; b32.wb_data = '0;
        b16.in_valid = 1'b0; b16.in_instr = '0; b16.out_ready = 1'b1;
        b16.wb_en = 1'b0; b16.wb_rd = '0; b16.wb_data = '0;
        tick();
        tick();
        chk("rst_vld", 128'(b32.out_valid), 128'(0));
        chk("rst_rec", 128'(obs32()), 128'(0));
        chk("rst_busy", 128'(u32.busy_q), 128'(0));
        rst = 1'b1;
        tick();
        chk("rst_rdy", 128'(b32.in_ready), 128'(1'b1));

        // write x1=10, x2=15, then ADD x3,x1,x2
        b32.wb_en = 1'b1; b32.wb_rd = 5'd1; b32.wb_data = 32'd10;
        tick();
        b32.wb_rd = 5'd2; b32.wb_data = 32'd15;
        tick();
        b32.wb_en = 1'b0;
        b32.in_valid = 1'b1; b32.in_instr = r_ins(F7_BASE, 5'd2, 5'd1, F3_ADD, 5'd3);
        #1 chk("add_rdy", 128'(b32.in_ready), 128'(1'b1));
        q.push_back('{sel: 1'b0, r: mk(OP_ADD, 5'd3, 32'd10, 32'd15, 32'd0, 1'b0, 1'b0), m: m_full});
        tick();
        b32.in_valid = 1'b0;
        pop_chk("add", 1'b0);
        chk("add_busy3", 128'(u32.busy_q[3]), 128'(1'b1));

        // ADDI x4,x0,-5
        b32.in_valid = 1'b1; b32.in_instr = i_ins(12'hFFB, 5'd0, F3_ADD, 5'd4);
        #1 chk("addi_rdy", 128'(b32.in_ready), 128'(1'b1));
        q.push_back('{sel: 1'b0, r: mk(OP_ADD, 5'd4, 32'd0, 32'd0, 32'hFFFF_FFFB, 1'b1, 1'b0), m: m_full});
        tick();
        b32.in_valid = 1'b0;
        pop_chk("addi", 1'b0);

        // SUB x5,x3,x1 stalls on busy x3 until x3=25 is written back
        b32.in_valid = 1'b1; b32.in_instr = r_ins(F7_ALT, 5'd1, 5'd3, F3_ADD, 5'd5);
        #1 chk("sub_stall", 128'(b32.in_ready), 128'(1'b0));
        tick();
        chk("sub_not_taken", 128'(b32.out_valid), 128'(1'b0));
        b32.wb_en = 1'b1; b32.wb_rd = 5'd3; b32.wb_data = 32'd25;
        #1 chk("sub_rdy_wb", 128'(b32.in_ready), 128'(1'b1));
        q.push_back('{sel: 1'b0, r: mk(OP_SUB, 5'd5, 32'd25, 32'd10, 32'd0, 1'b0, 1'b0), m: m_full});
        tick();
        b32.in_valid = 1'b0; b32.wb_en = 1'b0;
        pop_chk("sub", 1'b0);
        chk("busy3_clr", 128'(u32.busy_q[3]), 128'(1'b0));
        chk("busy5_set", 128'(u32.busy_q[5]), 128'(1'b1));

        // ADDI x6 accepted while x6 is written back: busy[6] stays set
        b32.in_valid = 1'b1; b32.in_instr = i_ins(12'd7, 5'd0, F3_ADD, 5'd6);
        b32.wb_en = 1'b1; b32.wb_rd = 5'd6; b32.wb_data = 32'd44;
        q.push_back('{sel: 1'b0, r: mk(OP_ADD, 5'd6, 32'd0, 32'd0, 32'd7, 1'b1, 1'b0), m: m_full});
        tick();
        b32.in_valid = 1'b0; b32.wb_en = 1'b0;
        pop_chk("addi_x6", 1'b0);
        chk("busy6_set_wins", 128'(u32.busy_q[6]), 128'(1'b1));

        // SRAI x8,x0,31: shift amount is zero-extended, not sign-extended [31:20]
        b32.in_valid = 1'b1; b32.in_instr = i_ins({F7_ALT, 5'd31}, 5'd0, F3_SR, 5'd8);
        q.push_back('{sel: 1'b0, r: mk(OP_SRA, 5'd8, 32'd0, 32'd0, 32'd31, 1'b1, 1'b0), m: m_full});
        tick();
        b32.in_valid = 1'b0;
        pop_chk("srai", 1'b0);

        // funct7 0000001 on ADD is not RV32I
        b32.in_valid = 1'b1; b32.in_instr = r_ins(7'b0000001, 5'd2, 5'd1, F3_ADD, 5'd9);
        q.push_back('{sel: 1'b0, r: mk(4'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1), m: m_ill});
        tick();
        b32.in_valid = 1'b0;
        pop_chk("bad_f7", 1'b0);
        chk("bad_f7_busy9", 128'(u32.busy_q[9]), 128'(1'b0));

        // ADD x7,x1,x2 held three cycles while x1 is rewritten to 99
        b32.in_valid = 1'b1; b32.in_instr = r_ins(F7_BASE, 5'd2, 5'd1, F3_ADD, 5'd7);
        q.push_back('{sel: 1'b0, r: mk(OP_ADD, 5'd7, 32'd10, 32'd15, 32'd0, 1'b0, 1'b0), m: m_full});
        tick();
        b32.in_valid = 1'b0; b32.out_ready = 1'b0;
        b32.wb_en = 1'b1; b32.wb_rd = 5'd1; b32.wb_data = 32'd99;
        for (int i = 0; i < 3; i++) begin
            chk("hold_rec", 128'(obs32()), 128'(q[0].r));
            chk("hold_rdy", 128'(b32.in_ready), 128'(1'b0));
            tick();
            b32.wb_en = 1'b0;
        end
        pop_chk("hold_final", 1'b0);
        b32.out_ready = 1'b1;
        b32.in_valid = 1'b1; b32.in_instr = r_ins(F7_BASE, 5'd0, 5'd1, F3_ADD, 5'd0);
        q.push_back('{sel: 1'b0, r: mk(OP_ADD, 5'd0, 32'd99, 32'd0, 32'd0, 1'b0, 1'b0), m: m_full});
        tick();
        b32.in_valid = 1'b0;
        pop_chk("x1_is_99", 1'b0);

        // reset while an output is held and x3 is busy
        b32.in_valid = 1'b1; b32.in_instr = r_ins(F7_BASE, 5'd2, 5'd1, F3_ADD, 5'd3);
        tick();
        b32.in_valid = 1'b0; b32.out_ready = 1'b0;
        chk("pre_rst_vld", 128'(b32.out_valid), 128'(1'b1));
        chk("pre_rst_busy3", 128'(u32.busy_q[3]), 128'(1'b1));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_rst_vld", 128'(b32.out_valid), 128'(1'b0));
        chk("mid_rst_busy", 128'(u32.busy_q), 128'(0));
        chk("mid_rst_rec", 128'(obs32()), 128'(0));
        #1 chk("mid_rst_rdy", 128'(b32.in_ready), 128'(1'b1));
        b32.out_ready = 1'b1;
        b32.in_valid = 1'b1; b32.in_instr = r_ins(F7_BASE, 5'd0, 5'd1, F3_ADD, 5'd0);
        q.push_back('{sel: 1'b0, r: mk(OP_ADD, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0), m: m_full});
        tick();
        b32.in_valid = 1'b0;
        pop_chk("x1_zero", 1'b0);

        // NREG=16 instance: out-of-range indices and unsupported opcode
        b16.in_valid = 1'b1; b16.in_instr = i_ins(12'd1, 5'd0, F3_ADD, 5'd17);
        q.push_back('{sel: 1'b1, r: mk(4'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1), m: m_ill});
        tick();
        b16.in_valid = 1'b0;
        pop_chk("rd17", 1'b1);
        chk("rd17_busy", 128'(u16.busy_q), 128'(0));

        b16.in_valid = 1'b1; b16.in_instr = {12'd4, 5'd1, 3'b010, 5'd2, 7'b0000011};
        q.push_back('{sel: 1'b1, r: mk(4'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1), m: m_ill});
        tick();
        b16.in_valid = 1'b0;
        pop_chk("load_opc", 1'b1);
        chk("load_busy", 128'(u16.busy_q), 128'(0));

        b16.in_valid = 1'b1; b16.in_instr = r_ins(F7_BASE, 5'd20, 5'd2, F3_ADD, 5'd1);
        q.push_back('{sel: 1'b1, r: mk(4'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1), m: m_ill});
        tick();
        b16.in_valid = 1'b0;
        pop_chk("rs2_20", 1'b1);
        chk("rs2_20_busy", 128'(u16.busy_q), 128'(0));

        b16.in_valid = 1'b1; b16.in_instr = i_ins(12'd3, 5'd0, F3_ADD, 5'd15);
        q.push_back('{sel: 1'b1, r: mk(OP_ADD, 5'd15, 32'd0, 32'd0, 32'd3, 1'b1, 1'b0), m: m_full});
        tick();
        b16.in_valid = 1'b0;
        pop_chk("x15_legal", 1'b1);
        chk("x15_busy", 128'(u16.busy_q), 128'(16'h8000));

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
